// File: rtl/pump_driver.sv
// pump_driver: turns the control FSM's pump request into a protected pump drive.
// Enforces minimum on/off times, a dry-run timeout and an immediate interlock trip.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | pump off, waiting for a request with interlock healthy
// RUN      | pump on, counting run time (min-on and dry-run timeout)
// COOLDOWN | pump off, counting minimum off time; requests ignored
// FAULT    | pump off, dry-run timeout latched until fault_clr with no request
module pump_driver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int MIN_ON_MS  = 2000,
    parameter int MIN_OFF_MS = 5000,
    parameter int MAX_ON_S   = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pump_req,
    input  logic       interlock_ok,
    input  logic       fault_clr,
    output logic       pump_on,
    output logic       fault,
    output logic [1:0] state
);

    // Limits are computed in 64 bits: the default dry-run limit exceeds 2^32 cycles.
    localparam longint unsigned ON_LIMIT  = (longint'(CLK_FREQ) / 1000) * longint'(MIN_ON_MS);
    localparam longint unsigned OFF_LIMIT = (longint'(CLK_FREQ) / 1000) * longint'(MIN_OFF_MS);
    localparam longint unsigned MAX_LIMIT = longint'(CLK_FREQ) * longint'(MAX_ON_S);
    localparam longint unsigned LIM_AB    = (ON_LIMIT > OFF_LIMIT) ? ON_LIMIT : OFF_LIMIT;
    localparam longint unsigned LIM_MAX   = (LIM_AB > MAX_LIMIT) ? LIM_AB : MAX_LIMIT;
    localparam int              CNT_W     = $clog2(LIM_MAX + 1);

    localparam logic [CNT_W-1:0] ON_M1  = CNT_W'(ON_LIMIT - 1);
    localparam logic [CNT_W-1:0] OFF_M1 = CNT_W'(OFF_LIMIT - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COOLDOWN = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t           state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;

    // State, shared counter and registered outputs; reset lands in COOLDOWN so
    // the minimum off time also applies after power-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= COOLDOWN;
            cnt_r   <= '0;
            pump_on <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            pump_on <= (state_nxt == RUN);
            fault   <= (state_nxt == FAULT);
        end
    end

    // Next-state decode; interlock beats the timeout, which beats a normal release.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (pump_req && interlock_ok)
                    state_nxt = RUN;
            end
            RUN: begin
                if (!interlock_ok)
                    state_nxt = COOLDOWN;
                else if (cnt_r == MAX_M1)
                    state_nxt = FAULT;
                else if (!pump_req && (cnt_r >= ON_M1))
                    state_nxt = COOLDOWN;
            end
            COOLDOWN: begin
                if (cnt_r == OFF_M1)
                    state_nxt = IDLE;
            end
            FAULT: begin
                if (fault_clr && !pump_req)
                    state_nxt = COOLDOWN;
            end
            default: state_nxt = COOLDOWN;
        endcase
    end

    // Counter restarts on every state change and only advances in timed states.
    always_comb begin
        cnt_nxt = cnt_r;
        if (state_nxt != state_r)
            cnt_nxt = '0;
        else if (state_r == RUN || state_r == COOLDOWN)
            cnt_nxt = cnt_r + CNT_W'(1);
    end

    assign state = state_r;

endmodule

// File: tb/tb_pump_driver.sv
// Directed bench for pump_driver with small limits (ON=5, OFF=3, MAX=1000 cycles).
module tb_pump_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pump_req = 1'b0;
    logic       interlock_ok = 1'b1;
    logic       fault_clr = 1'b0;
    logic       pump_on;
    logic       fault;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_COOL = 2'd2, S_FAULT = 2'd3;

    pump_driver #(
        .CLK_FREQ   (1000),
        .MIN_ON_MS  (5),
        .MIN_OFF_MS (3),
        .MAX_ON_S   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pump_req     (pump_req),
        .interlock_ok (interlock_ok),
        .fault_clr    (fault_clr),
        .pump_on      (pump_on),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int max_cyc);
        for (int i = 0; i < max_cyc && state != s; i++)
            tick();
        check("wait_state", state, s);
    endtask

    // Counts samples with pump_on high, ticking until it drops (bounded).
    task automatic count_on(output int cnt);
        cnt = 0;
        for (int i = 0; i < 1100 && pump_on; i++) begin
            cnt++;
            tick();
        end
    endtask

    // Counts samples spent in COOLDOWN, ticking until it is left (bounded).
    task automatic count_cool(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20 && state == S_COOL; i++) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        // reset state
        pump_req = 1'b1;
        tick();
        tick();
        check("rst_state", state, S_COOL);
        check("rst_pump_on", pump_on, 0);
        check("rst_fault", fault, 0);
        reset = 1'b0;

        // power-up cooldown, then IDLE for one cycle, then RUN
        count_cool(n);
        check("pwrup_cool_len", n, 3);
        check("pwrup_idle", state, S_IDLE);
        check("pwrup_idle_pump", pump_on, 0);
        tick();
        check("pwrup_run", state, S_RUN);
        check("pwrup_run_pump", pump_on, 1);
        check("pwrup_fault", fault, 0);

        // held request: dry-run timeout after exactly 1000 cycles
        count_on(n);
        check("dry_on_len", n, 1000);
        check("dry_fault", fault, 1);
        check("dry_state", state, S_FAULT);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_with_req_state", state, S_FAULT);
        check("clr_with_req_fault", fault, 1);
        interlock_ok = 1'b0;
        tick();
        check("fault_ilk_ignored", state, S_FAULT);
        interlock_ok = 1'b1;
        pump_req = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_fault", fault, 0);
        check("clr_state", state, S_COOL);
        count_cool(n);
        check("clr_cool_len", n, 3);
        check("clr_idle", state, S_IDLE);

        // single-cycle request gives a full min-on run
        pump_req = 1'b1;
        tick();
        pump_req = 1'b0;
        count_on(n);
        check("pulse_on_len", n, 5);
        check("pulse_cool", state, S_COOL);
        count_cool(n);
        check("pulse_cool_len", n, 3);
        check("pulse_idle", state, S_IDLE);

        // interlock trip at counter=2 overrides min-on
        pump_req = 1'b1;
        tick();
        check("ilk_run", state, S_RUN);
        tick();
        tick();
        interlock_ok = 1'b0;
        tick();
        check("ilk_pump_off", pump_on, 0);
        check("ilk_state", state, S_COOL);
        interlock_ok = 1'b1;
        pump_req = 1'b0;
        wait_state(S_IDLE, 10);

        // interlock trip on the timeout cycle wins: no fault
        pump_req = 1'b1;
        tick();
        for (int i = 0; i < 999; i++)
            tick();
        check("ilk999_still_run", state, S_RUN);
        interlock_ok = 1'b0;
        tick();
        check("ilk999_state", state, S_COOL);
        check("ilk999_fault", fault, 0);
        interlock_ok = 1'b1;
        pump_req = 1'b0;
        wait_state(S_IDLE, 10);

        // asynchronous reset mid-run
        pump_req = 1'b1;
        tick();
        tick();
        tick();
        check("arst_pre_run", pump_on, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pump_on", pump_on, 0);
        check("arst_state", state, S_COOL);
        tick();
        reset = 1'b0;
        count_cool(n);
        check("arst_cool_len", n, 3);
        check("arst_idle", state, S_IDLE);
        tick();
        check("arst_run", state, S_RUN);
        pump_req = 1'b0;
        wait_state(S_IDLE, 20);

        // request toggling inside COOLDOWN is ignored
        pump_req = 1'b1;
        tick();
        pump_req = 1'b0;
        wait_state(S_COOL, 10);
        pump_req = 1'b1;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("cool_req1_pump", pump_on, 0);
        check("cool_req1_state", state, S_COOL);
        pump_req = 1'b0;
        tick();
        check("cool_req0_pump", pump_on, 0);
        pump_req = 1'b1;
        tick();
        check("cool_end_idle", state, S_IDLE);
        check("cool_end_pump", pump_on, 0);
        tick();
        check("cool_restart_run", state, S_RUN);
        check("cool_restart_pump", pump_on, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pump_driver.md
Name: pump_driver

Overview:
- Output-side counterpart to the debounced level-sensor inputs: turns the control FSM's pump request into a protected pump/valve drive signal.
- Enforces a minimum on time and a minimum off time (anti short-cycle), a maximum continuous run time (dry-run protection) and an immediate interlock shutdown.
- Sits between the filter control logic and the pump output pin; `interlock_ok` is fed from an already-debounced level signal.

Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- MIN_ON_MS, 2000: minimum pump on time in ms.
- MIN_OFF_MS, 5000: minimum pump off time in ms.
- MAX_ON_S, 600: maximum continuous run time in s before fault.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pump_req  in  1  level request from control logic, synchronous to clk
- interlock_ok  in  1  1 = safe to run (debounced, synchronous); 0 forces pump off
- fault_clr  in  1  single-cycle pulse, clears fault
- pump_on  out  1  registered pump drive
- fault  out  1  registered dry-run timeout flag
- state  out  2  0=IDLE, 1=RUN, 2=COOLDOWN, 3=FAULT

Behaviour:
- One clock; reset is asynchronous and active-high.
- Cycle limits:
  - ON_LIMIT = (CLK_FREQ/1000)*MIN_ON_MS
  - OFF_LIMIT = (CLK_FREQ/1000)*MIN_OFF_MS
  - MAX_LIMIT = CLK_FREQ*MAX_ON_S
- Single shared counter, width $clog2(max(ON_LIMIT, OFF_LIMIT, MAX_LIMIT)+1). Cleared on every state entry; increments by 1 per cycle in RUN and COOLDOWN.
- All outputs are registered and change only on clk edges or on reset.
- Reset (asynchronous, any time, including mid-run):
  - state=COOLDOWN, counter=0, pump_on=0, fault=0.
  - Minimum off time is therefore enforced after power-up.
- IDLE (pump_on=0):
  - pump_req=1 and interlock_ok=1 → RUN at the next edge.
  - pump_on rises on that same edge, so latency is 1 cycle from the sampled request.
- RUN (pump_on=1), evaluated per cycle, in priority order:
  1. interlock_ok=0 → COOLDOWN at the next edge, regardless of min-on (interlock overrides min-on).
  2. Counter = MAX_LIMIT-1 → FAULT. pump_on is high exactly MAX_LIMIT cycles.
  3. pump_req=0 and counter ≥ ON_LIMIT-1 → COOLDOWN. An early release gives exactly ON_LIMIT cycles of pump_on.
  4. Otherwise stay in RUN.
- COOLDOWN (pump_on=0):
  - Stay until counter = OFF_LIMIT-1, then → IDLE. This gives OFF_LIMIT cycles in COOLDOWN.
  - pump_req and fault_clr are ignored. A held request starts RUN one cycle after IDLE is entered, so the minimum low time between runs is OFF_LIMIT+1 cycles.
- FAULT (pump_on=0, fault=1):
  - fault_clr=1 with pump_req=0 → COOLDOWN; fault drops on the same edge.
  - fault_clr while pump_req=1 is ignored, so the pump cannot restart straight out of a fault.
  - interlock_ok has no effect in FAULT.
- Simultaneous events:
  - interlock drop on the same cycle the timeout is reached → COOLDOWN, no fault.
  - Request release on the same cycle min-on expires → COOLDOWN.
  - A pump_req pulse shorter than one cycle in IDLE is not possible (synchronous input). A 1-cycle request still produces a full ON_LIMIT run.
- Counter never wraps: every counting state exits at its limit.

Test Plan (override CLK_FREQ=1000, MIN_ON_MS=5, MIN_OFF_MS=3, MAX_ON_S=1 → ON_LIMIT=5, OFF_LIMIT=3, MAX_LIMIT=1000):
- Reset release, pump_req=1, interlock_ok=1 held → state=COOLDOWN for 3 cycles, IDLE for 1 cycle, then pump_on=1 and state=RUN; fault stays 0.
- From IDLE, pump_req 1-cycle pulse → pump_on high exactly 5 cycles, then state=COOLDOWN for 3 cycles, then IDLE.
- pump_req held → pump_on high exactly 1000 cycles, then fault=1, state=3; fault_clr pulse with pump_req=1 → no change; drop pump_req, pulse fault_clr → fault=0, state=COOLDOWN.
- In RUN at counter=2, interlock_ok→0 → pump_on=0 on the next edge (min-on overridden), state=COOLDOWN; interlock_ok at counter=999 together with timeout → COOLDOWN, fault=0.
- Assert reset asynchronously mid-RUN (between edges) → pump_on=0 and state=2 immediately, without waiting for clk; after release, 3 COOLDOWN cycles before any restart.
- pump_req 1→0→1 within COOLDOWN → no pump_on until COOLDOWN completes; RUN begins one cycle after IDLE is entered.
